bus_master_seq: RTL and testbench

//  Command-driven bus master that drives the M0 port of the system bus, upstream of the bus/DMAC/factorial top level.

---
 rtl/bus_master_seq.sv | 214 +++++++++++++++++++++
 tb/tb_bus_master_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_seq.sv
// Command-queued bus master for the M0 port: WRITE/READ/WAIT_IRQ/NOP executed in order.
// Optional WAIT_IRQ watchdog built only when BMS_WATCHDOG_EN is defined.
module bus_master_seq #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        M0_req,
  output logic        M0_wr,
  output logic [7:0]  M0_address,
  output logic [31:0] M0_dout,
  input  logic        M0_grant,
  input  logic [31:0] M_din,
  input  logic        F_interrupt,
  input  logic        D_interrupt,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_WAIT  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RDATA,
    S_WAITI,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  // FIFO storage: {op, addr, data}
  logic [41:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [41:0]   head;

  op_e           lat_op_q, lat_op_d;
  logic [7:0]    lat_addr_q, lat_addr_d;
  logic [31:0]   lat_data_q, lat_data_d;

  logic          m0_req_q, m0_req_d;
  logic          m0_wr_q, m0_wr_d;
  logic [7:0]    m0_addr_q, m0_addr_d;
  logic [31:0]   m0_dout_q, m0_dout_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          irq_hit;
  logic          wd_expire;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  assign irq_hit = (lat_data_q[0] & F_interrupt) | (lat_data_q[1] & D_interrupt);

`ifdef BMS_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  // Counter is held at zero outside WAITI, so it is already cleared on entry.
  assign wd_expire = (state_q == S_WAITI) && !irq_hit && (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q | wd_expire;
    if (state_q == S_WAITI) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT);
  assign wd_expire      = 1'b0;
  assign err            = 1'b0;
`endif

  // FIFO pointers, occupancy and command latch
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    lat_op_d   = lat_op_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    if (pop) begin
      lat_op_d   = op_e'(head[41:40]);
      lat_addr_d = head[39:32];
      lat_data_d = head[31:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          case (lat_op_d)
            OP_WRITE, OP_READ: state_d = S_REQ;
            OP_WAIT:           state_d = (lat_data_d[1:0] == 2'b00) ? S_GAP : S_WAITI;
            default:           state_d = S_GAP;
          endcase
        end
      end
      S_REQ: begin
        if (M0_grant) begin
          state_d = (lat_op_q == OP_WRITE) ? S_GAP : S_RDATA;
        end
      end
      S_RDATA: state_d = S_GAP;
      S_WAITI: begin
        if (irq_hit || wd_expire) begin
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: bus outputs are registered from the next state and next command
  always_comb begin
    m0_req_d   = (state_d == S_REQ) || (state_d == S_RDATA);
    m0_wr_d    = m0_req_d && (lat_op_d == OP_WRITE);
    m0_addr_d  = m0_req_d ? lat_addr_d : '0;
    m0_dout_d  = m0_wr_d ? lat_data_d : '0;
    rd_valid_d = (state_q == S_RDATA);
    rd_data_d  = (state_q == S_RDATA) ? M_din : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lat_op_q   <= OP_NOP;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      m0_req_q   <= 1'b0;
      m0_wr_q    <= 1'b0;
      m0_addr_q  <= '0;
      m0_dout_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lat_op_q   <= lat_op_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      m0_req_q   <= m0_req_d;
      m0_wr_q    <= m0_wr_d;
      m0_addr_q  <= m0_addr_d;
      m0_dout_q  <= m0_dout_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_data};
    end
  end

  assign cmd_ready  = !full;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign M0_req     = m0_req_q;
  assign M0_wr      = m0_wr_q;
  assign M0_address = m0_addr_q;
  assign M0_dout    = m0_dout_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed self-checking bench for bus_master_seq (DEPTH=8, TIMEOUT=16).
module tb_bus_master_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        M0_req;
  logic        M0_wr;
  logic [7:0]  M0_address;
  logic [31:0] M0_dout;
  logic        M0_grant;
  logic [31:0] M_din = '0;
  logic        F_interrupt;
  logic        D_interrupt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];

  bus_master_seq #(.DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
    .M0_grant(M0_grant), .M_din(M_din),
    .F_interrupt(F_interrupt), .D_interrupt(D_interrupt),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous slave RAM: one-cycle read latency
  always @(posedge clk) begin
    M_din <= (M0_address == 8'h21) ? 32'h1234_5678 : (32'hBAD0_0000 | 32'(M0_address));
  end

  // Completed write data phases
  always @(negedge clk) begin
    if (reset_n && M0_req && M0_grant && M0_wr) begin
      log_addr.push_back(M0_address);
      log_data.push_back(M0_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic measure_rises(input string tag, input logic [31:0] exp_gap);
    logic prev = 1'b0;
    int   r0 = -1;
    int   r1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (M0_req && !prev) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
      prev = M0_req;
      step();
    end
    check(tag, 32'(r1 - r0), exp_gap);
  endtask

  int          base;
  int          req_cnt;
  int          accepted;
  int          n;
  logic        cap_wr;
  logic [7:0]  cap_addr;
  logic [31:0] cap_dout;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    M0_grant = 1'b0; F_interrupt = 1'b0; D_interrupt = 1'b0;

    // T1 reset
    step(); step();
    check("t1_req", M0_req, 1'b0);
    check("t1_wr", M0_wr, 1'b0);
    check("t1_addr", M0_address, 8'h00);
    check("t1_dout", M0_dout, 32'h0);
    check("t1_rd_valid", rd_valid, 1'b0);
    check("t1_rd_data", rd_data, 32'h0);
    check("t1_err", err, 1'b0);
    check("t1_ready", cmd_ready, 1'b1);
    check("t1_busy", busy, 1'b0);
    reset_n = 1'b1;
    step();
    check("t1_busy_after_release", busy, 1'b0);

    // T2 single write, grant tied high
    M0_grant = 1'b1;
    base = log_addr.size();
    push_cmd(2'b01, 8'h20, 32'hDEAD_BEEF);
    check("t2_busy_queued", busy, 1'b1);
    req_cnt = 0; cap_wr = 1'b0; cap_addr = '0; cap_dout = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (M0_req) begin
        req_cnt++;
        cap_wr = M0_wr; cap_addr = M0_address; cap_dout = M0_dout;
      end
    end
    check("t2_req_cycles", 32'(req_cnt), 32'd1);
    check("t2_wr", cap_wr, 1'b1);
    check("t2_addr", cap_addr, 8'h20);
    check("t2_dout", cap_dout, 32'hDEAD_BEEF);
    check("t2_idle", busy, 1'b0);
    check("t2_logged", 32'(log_addr.size() - base), 32'd1);

    // Back-to-back latency: writes start 3 cycles apart, reads 4
    push_cmd(2'b01, 8'h30, 32'h30);
    push_cmd(2'b01, 8'h31, 32'h31);
    measure_rises("lat_write", 32'd3);
    wait_idle("lat_write_idle", 20);
    push_cmd(2'b10, 8'h32, 32'h0);
    push_cmd(2'b10, 8'h33, 32'h0);
    measure_rises("lat_read", 32'd4);
    wait_idle("lat_read_idle", 20);

    // T3 read with grant delayed, then grant lost during RDATA
    M0_grant = 1'b0;
    push_cmd(2'b10, 8'h21, 32'h0);
    n = 0;
    while (!M0_req && n < 10) begin
      step();
      n++;
    end
    check("t3_req1", M0_req, 1'b1);
    check("t3_wr", M0_wr, 1'b0);
    check("t3_addr", M0_address, 8'h21);
    step();
    check("t3_req2", M0_req, 1'b1);
    step();
    check("t3_req3", M0_req, 1'b1);
    M0_grant = 1'b1;
    step();
    check("t3_rdata_req", M0_req, 1'b1);
    check("t3_rdata_no_valid", rd_valid, 1'b0);
    M0_grant = 1'b0;
    step();
    check("t3_valid", rd_valid, 1'b1);
    check("t3_data", rd_data, 32'h1234_5678);
    check("t3_gap_req", M0_req, 1'b0);
    step();
    check("t3_valid_pulse", rd_valid, 1'b0);
    check("t3_data_held", rd_data, 32'h1234_5678);
    wait_idle("t3_idle", 10);

    // T4 FIFO full with grant held low
    base = log_addr.size();
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_addr  = 8'h40 + 8'(i);
      cmd_data  = 32'h1000 + 32'(i);
      if (i == 9) check("t4_ready_low_when_full", cmd_ready, 1'b0);
      if (cmd_ready) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    check("t4_accepted", 32'(accepted), 32'd9);
    check("t4_stuck_req", M0_req, 1'b1);
    check("t4_stuck_addr", M0_address, 8'h40);
    M0_grant = 1'b1;
    wait_idle("t4_drain", 200);
    check("t4_count", 32'(log_addr.size() - base), 32'd9);
    for (int k = 0; k < 9; k++) begin
      if (base + k < log_addr.size()) begin
        check("t4_order_addr", log_addr[base+k], 8'h40 + 8'(k));
        check("t4_order_data", log_data[base+k], 32'h1000 + 32'(k));
      end
    end

    // NOP and WAIT_IRQ with zero mask pass straight through
    push_cmd(2'b00, 8'h00, 32'h0);
    push_cmd(2'b11, 8'h00, 32'h0);
    wait_idle("nop_mask0_idle", 12);
    check("nop_no_req", M0_req, 1'b0);

    // T5 WAIT_IRQ on D only
    base = log_addr.size();
    push_cmd(2'b11, 8'h00, 32'h2);
    push_cmd(2'b01, 8'h55, 32'hA5A5_A5A5);
    step(); step(); step();
    F_interrupt = 1'b1;
    step();
    F_interrupt = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t5_still_waiting", 32'(log_addr.size() - base), 32'd0);
    check("t5_wait_no_req", M0_req, 1'b0);
    check("t5_wait_busy", busy, 1'b1);
    D_interrupt = 1'b1;
    step();
    D_interrupt = 1'b0;
    check("t5_gap_req", M0_req, 1'b0);
    step();
    check("t5_idle_req", M0_req, 1'b0);
    step();
    check("t5_write_req", M0_req, 1'b1);
    check("t5_write_addr", M0_address, 8'h55);
    check("t5_write_dout", M0_dout, 32'hA5A5_A5A5);
    wait_idle("t5_idle", 10);
    check("t5_logged", 32'(log_addr.size() - base), 32'd1);

    // T6 watchdog
    base = log_addr.size();
    push_cmd(2'b11, 8'h00, 32'h1);
    push_cmd(2'b01, 8'h66, 32'h66);
`ifdef BMS_WATCHDOG_EN
    n = 0;
    while (!err && n < 40) begin
      step();
      n++;
    end
    check("t6_err", err, 1'b1);
    check("t6_err_cycles", 32'(n), 32'd16);
    wait_idle("t6_idle", 20);
    check("t6_logged", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() > base) check("t6_addr", log_addr[base], 8'h66);
    check("t6_err_sticky", err, 1'b1);
`else
    for (int i = 0; i < 40; i++) step();
    check("t6_no_err", err, 1'b0);
    check("t6_still_busy", busy, 1'b1);
    check("t6_no_req", M0_req, 1'b0);
    check("t6_no_write", 32'(log_addr.size() - base), 32'd0);
`endif

    // Reset mid-operation
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    M0_grant = 1'b0;
    push_cmd(2'b01, 8'h77, 32'h77);
    n = 0;
    while (!M0_req && n < 10) begin
      step();
      n++;
    end
    check("rst_req_before", M0_req, 1'b1);
    reset_n = 1'b0;
    step();
    check("rst_req_dropped", M0_req, 1'b0);
    check("rst_addr", M0_address, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
